top: RTL and testbench

Sine-modulated PWM tone generator driving a single-bit buzzer output (`bell`). A 36-entry sine table sets the PWM duty on a 6-bit (64-step) carrier, and the 12-bit input `N` sets the pitch by slowing the carrier clock. This is the top-level block of the bell/tone subsystem: it connects directly to the board clock and the buzzer pin.

---
 rtl/top_if.sv | 7 +
 rtl/top.sv | 49 ++++
 tb/tb_top.sv | 118 +++++++++++
 3 files changed

// File: rtl/top_if.sv
// top_if: pitch input and buzzer output of the tone generator
interface top_if;
  logic [11:0] N;
  logic bell;
  modport master(output N, input bell);
  modport slave(input N, output bell);
endinterface

// File: rtl/top.sv
// top: sine-modulated PWM tone generator driving a buzzer
module top #(
  parameter int R = 6,
  parameter int SAMPLES = 36,
  parameter int REPEAT = 2
) (
  input logic clk,
  input logic reset,
  top_if.slave io
);
  localparam int RW = REPEAT > 1 ? $clog2(REPEAT) : 1;
  localparam int SW = $clog2(SAMPLES);
  // round-half-up(32 + 31*sin(10 deg * k))
  localparam logic [R-1:0] SINE [36] = '{
    32, 37, 43, 48, 52, 56, 59, 61, 63, 63, 63, 61, 59, 56, 52, 48, 43, 37,
    32, 27, 21, 17, 12,  8,  5,  3,  1,  1,  1,  3,  5,  8, 12, 17, 21, 27
  };
  logic [11:0] p, lim;
  logic [R-1:0] c, d;
  logic [RW-1:0] r;
  logic [SW-1:0] s, s_nxt;
  logic tick, wrap, adv;
  // >= rather than == so lowering N mid-count never skips past the limit
  always_comb begin
    lim = (io.N == 12'd0) ? 12'd0 : io.N - 12'd1;
    tick = p >= lim;
    wrap = tick && (c == '1);
    adv = wrap && (r == RW'(REPEAT - 1));
    s_nxt = adv ? ((s == SW'(SAMPLES - 1)) ? '0 : s + 1'b1) : s;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p <= '0;
      c <= '0;
      r <= '0;
      s <= '0;
      d <= SINE[0];
      io.bell <= 1'b0;
    end else begin
      p <= tick ? '0 : p + 12'd1;
      if (tick) c <= c + 1'b1;
      if (wrap) begin
        r <= adv ? '0 : r + 1'b1;
        s <= s_nxt;
        d <= SINE[s_nxt];
      end
      io.bell <= c < d;
    end
endmodule

// File: tb/tb_top.sv
// tb_top: scoreboard bench measuring bell high time and period between rising edges
module tb_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  top_if bus();
  top dut(.clk(clk), .reset(reset), .io(bus));
  typedef struct {int hi; int len;} per_t;
  per_t exp_q[$];
  per_t e;
  int compared = 0, mismatched = 0;
  int rises = 0, cyc = 0, first_cyc = 0, last_cyc = 0, hi = 0, len = 0;
  logic prev = 1'b0;
  int sine [36] = '{
    32, 37, 43, 48, 52, 56, 59, 61, 63, 63, 63, 61, 59, 56, 52, 48, 43, 37,
    32, 27, 21, 17, 12,  8,  5,  3,  1,  1,  1,  3,  5,  8, 12, 17, 21, 27
  };

  task automatic chk(string name, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(int h, int l);
    per_t x;
    x.hi = h;
    x.len = l;
    exp_q.push_back(x);
  endtask

  // each rising edge closes the previous PWM period and checks it
  always @(negedge clk) begin
    if (!reset) begin
      prev = 1'b0;
      rises = 0;
      cyc = 0;
      hi = 0;
      len = 0;
    end else begin
      cyc++;
      if (bus.bell && !prev) begin
        if (rises > 0 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("period_high", hi, e.hi);
          chk("period_len", len, e.len);
        end
        rises++;
        if (rises == 1) first_cyc = cyc;
        last_cyc = cyc;
        hi = 0;
        len = 0;
      end
      len++;
      if (bus.bell) hi++;
      prev = bus.bell;
    end
  end

  task automatic do_reset(int n);
    #3 reset = 1'b0;
    #1 chk("bell_in_reset", int'(bus.bell), 0);
    bus.N = 12'(n);
    @(negedge clk);
    @(negedge clk);
    chk("bell_held_reset", int'(bus.bell), 0);
    reset = 1'b1;
  endtask

  task automatic wait_rises(int target, int budget);
    for (int i = 0; i < budget && rises < target; i++) @(negedge clk);
    chk("rises_reached", int'(rises >= target), 1);
  endtask

  task automatic tone(int n);
    int ne;
    ne = (n == 0) ? 1 : n;
    for (int j = 0; j < 72; j++) push(sine[j / 2] * ne, 64 * ne);
    do_reset(n);
    wait_rises(73, 4608 * ne + 200);
    chk("queue_drained", exp_q.size(), 0);
    chk("tone_period", last_cyc - first_cyc, 4608 * ne);
  endtask

  initial begin
    bus.N = 12'd1;
    tone(1);
    tone(0);
    tone(2);
    tone(3);
    tone(4);
    // N drops 4 -> 1 one clock after release: c=0 lasts two clocks, then full speed
    push(33, 65);
    push(32, 64);
    push(37, 64);
    push(37, 64);
    do_reset(4);
    @(negedge clk);
    bus.N = 12'd1;
    wait_rises(5, 600);
    chk("queue_drained_nchg", exp_q.size(), 0);
    // run into sample 20 (duty 21), then reset asynchronously while bell is high
    do_reset(1);
    wait_rises(41, 40 * 64 + 200);
    repeat (5) @(negedge clk);
    chk("bell_high_s20", int'(bus.bell), 1);
    push(32, 64);
    push(32, 64);
    push(37, 64);
    do_reset(1);
    wait_rises(4, 400);
    chk("queue_drained_rst", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
